// File: rtl/obi_sram_device_pkg.sv
// Shared OBI constants, the response record carried through the response
// pipeline, and the byte-enable merge used by the memory write path.
package obi_sram_device_pkg;

  localparam int OBI_DATA_W = 64;
  localparam int OBI_BE_W   = 8;
  localparam int OBI_OFFS_W = 3;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_resp_t;

  function automatic logic [OBI_DATA_W-1:0] be_merge(
    input logic [OBI_DATA_W-1:0] old_w,
    input logic [OBI_DATA_W-1:0] new_w,
    input logic [OBI_BE_W-1:0]   be
  );
    logic [OBI_DATA_W-1:0] merged;
    merged = old_w;
    for (int n = 0; n < OBI_BE_W; n++) begin
      if (be[n]) merged[8*n +: 8] = new_w[8*n +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/obi_sram_device_if.sv
// OBI data-memory bus between a host driver (master) and a device (slave).
interface obi_sram_device_if;
  import obi_sram_device_pkg::*;

  logic                  req;
  logic                  gnt;
  logic                  we;
  logic [OBI_BE_W-1:0]   be;
  logic [63:0]           addr;
  logic [OBI_DATA_W-1:0] wdata;
  logic                  rvalid;
  logic [OBI_DATA_W-1:0] rdata;
  logic                  err;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_resp_pipe.sv
// Fixed-latency shift register of OBI responses; the last stage is the
// registered response presented to the host.
module obi_resp_pipe
  import obi_sram_device_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      clr_i,
  input  obi_resp_t in_i,
  output obi_resp_t out_o
);

  obi_resp_t stage_q [LATENCY];

  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // old value on the same edge, which is what makes this a shift register.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_i;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/obi_sram_device.sv
// OBI responder backed by a 64-bit synchronous memory, with configurable
// response latency and a cap on accepted-but-unanswered requests.
module obi_sram_device
  import obi_sram_device_pkg::*;
#(
  parameter int MEM_WORDS       = 512,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               gnt_stall_i,
  obi_sram_device_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("obi_sram_device: LATENCY must be in 1..4");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_outstanding
    $error("obi_sram_device: MAX_OUTSTANDING must be in 1..LATENCY+1");
  end

  logic [OBI_DATA_W-1:0] mem_q [MEM_WORDS];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [63-OBI_OFFS_W:0] idx_full;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  accept;
  obi_resp_t             resp_in, resp_out;

  assign idx_full = bus.addr[63:OBI_OFFS_W];
  assign in_range = idx_full < (64-OBI_OFFS_W)'(MEM_WORDS);
  assign idx      = idx_full[IDX_W-1:0];

  // Grant depends only on local state so the host never sees a req->gnt path.
  assign bus.gnt = ~rst_i & ~gnt_stall_i & (cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign accept  = bus.req & bus.gnt;

  // NOTE: every field gets a default before the conditional updates, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    resp_in       = '0;
    resp_in.valid = accept;
    resp_in.err   = accept & ~in_range;
    if (accept && !bus.we && in_range) resp_in.rdata = mem_q[idx];
  end

  // NOTE: the array has no reset branch; contents survive rst_i and an
  // unreset array can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (accept && bus.we && in_range) begin
      mem_q[idx] <= be_merge(mem_q[idx], bus.wdata, bus.be);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, resp_out.valid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  obi_resp_pipe #(.LATENCY(LATENCY)) u_resp_pipe (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .in_i  (resp_in),
    .out_o (resp_out)
  );

  assign bus.rvalid = resp_out.valid;
  assign bus.rdata  = resp_out.rdata;
  assign bus.err    = resp_out.err;

  a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= CNT_W'(MAX_OUTSTANDING));
  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(cnt_q == '0 && resp_out.valid));

endmodule
